// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard sequencer and decoder.
//   state_t         sequencer states (RUN, DRAIN, HALTED)
//   HALT_*_INSN     the two-instruction termination sequence recognised by the decoder
//   CTRL_*          control vectors, bit order
//                   {pc_write, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, flush_id_ex}
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // addi x1,x0,12 marks the following jalr x0,0(x1) as the program exit
    localparam logic [31:0] HALT_MARKER_INSN = 32'h00c00093;
    localparam logic [31:0] HALT_JALR_INSN   = 32'h00008067;

    localparam logic [6:0] CTRL_FREEZE   = 7'b0000000;
    localparam logic [6:0] CTRL_RESET    = 7'b0000011;
    localparam logic [6:0] CTRL_RUN      = 7'b1111100;
    localparam logic [6:0] CTRL_REDIRECT = 7'b1111111;
    localparam logic [6:0] CTRL_BUBBLE   = 7'b0011101;
    localparam logic [6:0] CTRL_HALT_ID  = 7'b0111110;
    localparam logic [6:0] CTRL_DRAIN    = 7'b0111111;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard compare between ID and EX.
//   i_ex_valid, i_ex_is_load, i_ex_rd          EX stage load description
//   i_id_valid, i_id_rs1/2, i_id_uses_rs1/2    ID stage source operands
//   o_load_use                                 ID needs a value EX has not loaded yet
module load_use_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    // x0 is hardwired, so a load into it never creates a dependency
    assign o_load_use = i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) && i_id_valid
                        && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with drain-to-halt.
//   CLK, RSTn                         clock, synchronous active-low reset
//   id_* / ex_* / mem_wait            hazard sources from ID, EX and data memory
//   pc_write, *_we                    PC and pipeline register write enables (Mealy)
//   flush_if_id, flush_id_ex          load a NOP into that register when its enable is 1
//   halt                              registered, program terminated
//   stall_cycles, flush_count         saturating performance counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_halt,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mispredict,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_cnt;
    logic [DW-1:0]    w_cnt_nxt;
    logic             r_halt;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;
    logic [6:0]       w_ctrl;
    logic             w_load_use;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic             w_go_drain;

    load_use_detect u_lud (
        .i_ex_valid    (ex_valid),
        .i_ex_is_load  (ex_is_load),
        .i_ex_rd       (ex_rd),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .o_load_use    (w_load_use)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_halt  <= (w_state_nxt == HALTED);
        end
    end

    // Drain count only advances on cycles the pipeline actually moves
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                w_state_nxt = w_go_drain ? DRAIN : RUN;
                w_cnt_nxt   = w_go_drain ? DW'(DRAIN_CYCLES) : r_cnt;
            end
            DRAIN: begin
                w_state_nxt = (!mem_wait && r_cnt == DW'(1)) ? HALTED : DRAIN;
                w_cnt_nxt   = mem_wait ? r_cnt : r_cnt - DW'(1);
            end
            default: ;
        endcase
    end

    // Priority in RUN: freeze > redirect > load-use bubble > halt entry
    always_comb begin
        w_ctrl      = CTRL_FREEZE;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        w_go_drain  = 1'b0;
        if (!RSTn) begin
            w_ctrl = CTRL_RESET;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_wait) begin
                        w_stall_inc = 1'b1;
                    end else if (ex_valid && ex_mispredict) begin
                        w_ctrl      = CTRL_REDIRECT;
                        w_flush_inc = 1'b1;
                    end else if (w_load_use) begin
                        w_ctrl      = CTRL_BUBBLE;
                        w_stall_inc = 1'b1;
                    end else if (id_valid && id_halt) begin
                        w_ctrl     = CTRL_HALT_ID;
                        w_go_drain = 1'b1;
                    end else begin
                        w_ctrl = CTRL_RUN;
                    end
                end
                DRAIN: begin
                    w_ctrl      = mem_wait ? CTRL_FREEZE : CTRL_DRAIN;
                    w_stall_inc = mem_wait;
                end
                default: ;
            endcase
        end
    end

    assign {pc_write, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, flush_id_ex} = w_ctrl;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (w_stall_inc && r_stall != '1)
                r_stall <= r_stall + CNT_W'(1);
            if (w_flush_inc && r_flush != '1)
                r_flush <= r_flush + CNT_W'(1);
        end
    end

    assign halt         = r_halt;
    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl with directed and random stimulus.
module tb_pipe_hazard_ctrl;

    localparam int DC   = 3;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic       rstn;
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       idh;
        logic       exv;
        logic       exl;
        logic [4:0] rd;
        logic       mp;
        logic       mw;
    } in_t;

    typedef struct packed {
        logic [6:0]    ctrl;
        logic          halt;
        logic [CW-1:0] st;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_halt;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          ex_valid, ex_is_load, ex_mispredict, mem_wait;
    logic          pc_write, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic          flush_if_id, flush_id_ex, halt;
    logic [CW-1:0] stall_cycles, flush_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];

    // Reference model state: cycles of drain left (0 = not draining), halted flag, counters
    bit m_halted = 0;
    int m_drain  = 0;
    int m_st     = 0;
    int m_fc     = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .CLK           (clk),
        .RSTn          (rstn),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_halt       (id_halt),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_rd         (ex_rd),
        .ex_mispredict (ex_mispredict),
        .mem_wait      (mem_wait),
        .pc_write      (pc_write),
        .if_id_we      (if_id_we),
        .id_ex_we      (id_ex_we),
        .ex_mem_we     (ex_mem_we),
        .mem_wb_we     (mem_wb_we),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .halt          (halt),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    // Expected {pc,ifid,idex,exmem,memwb,flush_ifid,flush_idex} for these inputs, then advance the model
    task automatic model(input in_t s, output exp_t e);
        bit lu;
        e.halt = m_halted;
        e.st   = CW'(m_st);
        e.fc   = CW'(m_fc);
        lu = s.exv && s.exl && (s.rd != 0) && s.idv
             && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (!s.rstn) begin
            e.ctrl = 7'b0000011;
            m_halted = 0; m_drain = 0; m_st = 0; m_fc = 0;
        end else if (m_halted) begin
            e.ctrl = 7'b0000000;
        end else if (m_drain > 0) begin
            if (s.mw) begin
                e.ctrl = 7'b0000000;
                m_st = sat(m_st);
            end else begin
                e.ctrl = 7'b0111111;
                m_drain--;
                if (m_drain == 0) m_halted = 1;
            end
        end else if (s.mw) begin
            e.ctrl = 7'b0000000;
            m_st = sat(m_st);
        end else if (s.exv && s.mp) begin
            e.ctrl = 7'b1111111;
            m_fc = sat(m_fc);
        end else if (lu) begin
            e.ctrl = 7'b0011101;
            m_st = sat(m_st);
        end else if (s.idv && s.idh) begin
            e.ctrl = 7'b0111110;
            m_drain = DC;
        end else begin
            e.ctrl = 7'b1111100;
        end
    endtask

    task automatic apply(input in_t s);
        rstn = s.rstn; id_valid = s.idv; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_halt = s.idh;
        ex_valid = s.exv; ex_is_load = s.exl; ex_rd = s.rd;
        ex_mispredict = s.mp; mem_wait = s.mw;
    endtask

    task automatic step(input in_t s);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        model(s, e);
        q.push_back(e);
    endtask

    function automatic in_t idle();
        in_t s = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    function automatic in_t rnd();
        in_t s;
        s.rstn = ($urandom_range(99) != 0);
        s.idv  = ($urandom_range(3) != 0);
        s.rs1  = 5'($urandom_range(3));
        s.rs2  = 5'($urandom_range(3));
        s.u1   = 1'($urandom_range(1));
        s.u2   = 1'($urandom_range(1));
        s.idh  = ($urandom_range(19) == 0);
        s.exv  = ($urandom_range(3) != 0);
        s.exl  = 1'($urandom_range(1));
        s.rd   = 5'($urandom_range(3));
        s.mp   = ($urandom_range(6) == 0);
        s.mw   = ($urandom_range(4) == 0);
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ({pc_write, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, flush_id_ex} === e.ctrl)
                n_pass++;
            else
                $display("FAIL ctrl t=%0t got %b want %b", $time,
                         {pc_write, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, flush_id_ex}, e.ctrl);
            n_checks++;
            if (halt === e.halt) n_pass++;
            else $display("FAIL halt t=%0t got %b want %b", $time, halt, e.halt);
            n_checks++;
            if (stall_cycles === e.st && flush_count === e.fc) n_pass++;
            else $display("FAIL counters t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                          $time, stall_cycles, flush_count, e.st, e.fc);
        end
    end

    initial begin
        in_t s, lu_in, rst_in;
        rst_in = idle();
        rst_in.rstn = 1'b0;
        apply(rst_in);
        @(posedge clk);
        step(rst_in);
        // load-use: lw x5 in EX, add x6,x5,x7 in ID
        lu_in = idle();
        lu_in.exv = 1; lu_in.exl = 1; lu_in.rd = 5'd5;
        lu_in.idv = 1; lu_in.rs1 = 5'd5; lu_in.rs2 = 5'd7; lu_in.u1 = 1; lu_in.u2 = 1;
        step(lu_in);
        s = idle(); s.idv = 1; s.rs1 = 5'd5; s.u1 = 1;
        step(s);
        // load into x0 and an unused matching source never stall
        s = lu_in; s.rd = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd9;
        step(s);
        s = lu_in; s.u1 = 0;
        step(s);
        // mispredict together with a wrong-path halt
        s = idle(); s.exv = 1; s.mp = 1; s.idv = 1; s.idh = 1;
        step(s);
        step(idle());
        // halt with no waits, then sit in HALTED, then reset out of it
        s = idle(); s.idv = 1; s.idh = 1;
        step(s);
        for (int i = 0; i < DC + 3; i++) step(idle());
        step(rst_in);
        step(idle());
        // halt with two memory waits inside the drain
        s = idle(); s.idv = 1; s.idh = 1;
        step(s);
        step(idle());
        s = idle(); s.mw = 1;
        step(s);
        step(s);
        for (int i = 0; i < DC + 2; i++) step(idle());
        step(rst_in);
        // load-use frozen by four memory waits, then its single bubble
        for (int i = 0; i < 4; i++) begin
            s = lu_in; s.mw = 1;
            step(s);
        end
        step(lu_in);
        step(idle());
        step(idle());
        for (int i = 0; i < 3000; i++) step(rnd());
        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It arbitrates between memory wait, branch misprediction, load-use hazards and program termination. It drives the PC and pipeline-register write enables and NOP-injection controls, drains the pipeline on the termination sequence, and asserts HALT. It also keeps stall and flush performance counters for the testbench.

## Interface
- DRAIN_CYCLES, 3, cycles to let in-flight instructions (EX, MEM, WB) retire after termination is detected in ID
- CNT_W, 32, width of performance counters
- CLK  in  1  clock, all state updates on rising edge
- RSTn  in  1  reset, synchronous, active-low
- id_valid  in  1  IF/ID holds a real (non-bubble) instruction
- id_rs1, id_rs2  in  5 each  source registers of the ID instruction
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- id_halt  in  1  ID instruction is the decoded termination instruction (`jalr x0,0(x1)` preceded by the `x1=12` marker)
- ex_valid  in  1  ID/EX holds a real instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_mispredict  in  1  EX branch/jump resolved differently from the BTB prediction
- mem_wait  in  1  D-memory not ready; whole pipeline must freeze
- pc_write  out  1  PC may update
- if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  pipeline register write enables
- flush_if_id, flush_id_ex  out  1 each  load NOP into that register on this edge (valid only when its we=1)
- halt  out  1  registered; program terminated
- stall_cycles, flush_count  out  CNT_W each  saturating performance counters

## Operation
- States: RUN, DRAIN, HALTED. Registered state and drain counter. Enables and flushes are combinational (Mealy) from state and inputs.
- RSTn=0: all write enables 0, both flushes 1. On the edge, state goes to RUN, the counter to 0, halt to 0 and both performance counters to 0.
- RUN priority, highest first:
  - mem_wait: all write enables 0, no flush. stall_cycles+1.
  - ex_valid & ex_mispredict: all enables 1, flush_if_id=1, flush_id_ex=1. flush_count+1. PC takes the redirect.
  - load-use: true when ex_valid & ex_is_load & ex_rd≠0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
    - pc_write=0, if_id_we=0, id_ex_we=1 with flush_id_ex=1 (bubble), ex_mem_we=mem_wb_we=1. stall_cycles+1.
  - id_valid & id_halt: all enables 1 except pc_write=0; flush_if_id=1. Go to DRAIN, drain counter=DRAIN_CYCLES.
  - else: all enables 1, no flush.
- DRAIN:
  - pc_write=0, if_id_we=1 with flush_if_id=1, id_ex_we=1 with flush_id_ex=1. ex_mem_we=mem_wb_we=1.
  - The counter decrements each cycle. When it reaches 1 and is decremented, go to HALTED, halt←1.
  - mem_wait: all enables 0, counter holds, stall_cycles+1.
  - ex_mispredict is ignored, because the halt instruction is the youngest remaining.
- HALTED: all enables 0, no flush, halt=1. Leaves only via reset.
- Counters saturate at 2^CNT_W−1. They never wrap.

## Timing
- Stall and flush decisions act on the same rising edge as the triggering inputs (0-cycle latency).
- Load-use costs exactly 1 bubble. A mispredict costs 2 bubbles.
- halt rises on the DRAIN_CYCLES-th edge after the edge that left RUN, not counting mem_wait cycles.
- mispredict and id_halt in the same cycle: mispredict wins and state stays RUN, because the halt instruction is wrong-path.
- mem_wait together with any other event: freeze wins, and the event is re-evaluated next cycle from the held inputs.
- RSTn low mid-DRAIN or in HALTED: the next edge returns to RUN with halt=0.

## Structure
- Shared package `pipe_ctrl_pkg`: state enum (RUN, DRAIN, HALTED) and the termination encodings 32'h00c00093 and 32'h00008067, shared with the decoder.
- Sub-module `load_use_detect`: purely combinational hazard compare. Everything else stays in the top FSM.

## Test plan
- Load-use: EX `lw x5`, ID `add x6,x5,x7` → one cycle with pc_write=0, if_id_we=0, flush_id_ex=1. stall_cycles=1. Next cycle all enables 1.
- ex_rd=0 load with matching rs1=0 → no stall. Same case with id_uses_rs1=0 → no stall.
- Mispredict in EX → flush_if_id=flush_id_ex=1, pc_write=1 for one cycle. flush_count=1. Same cycle id_halt=1 → state remains RUN.
- id_halt with DRAIN_CYCLES=3, no waits → halt=1 exactly 3 edges after leaving RUN. With mem_wait held 2 cycles during DRAIN → 5 edges.
- mem_wait held 4 cycles during a load-use → all enables 0 for 4 cycles, then a 1-cycle bubble. stall_cycles=5.
- Reset asserted in HALTED → next edge halt=0, counters 0, all enables 1 once RSTn=1.
